// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: CS low for FRAME_BYTES bytes, then CS_GAP high; SPI_FRAME_CHECKSUM_EN appends a mod-256 sum byte.
// Latency: CLK_DIV setup + 16*CLK_DIV per byte in SHIFT, CLK_DIV hold, CS_GAP gap; every output is registered.
// Backpressure: tx_ready only in IDLE/NEXT; tx_valid low in NEXT stalls with CS held low and SCK idle, no timeout.
module spi_frame_master #(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BYTES = 6144,
    parameter int CS_GAP      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sck,
    output logic       mosi,
    output logic       cs,
    input  logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(FRAME_BYTES);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT, HOLD, GAP} state_t;

    state_t           state, state_nxt;
    logic [7:0]       sr, sr_nxt, rx_sr, rx_sr_nxt, rx_data_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [CNT_W-1:0] byte_cnt, byte_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             sck_nxt, mosi_nxt, cs_nxt, ready_nxt, busy_nxt, rx_valid_nxt, done_nxt;
    logic             accept;
`ifdef SPI_FRAME_CHECKSUM_EN
    logic [7:0]       csum, csum_nxt;
    logic             csum_sent, csum_sent_nxt;
`endif

    assign accept = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            cs         <= 1'b1;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum       <= '0;
            csum_sent  <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            rx_sr      <= rx_sr_nxt;
            bit_cnt    <= bit_nxt;
            div_cnt    <= div_nxt;
            byte_cnt   <= byte_nxt;
            gap_cnt    <= gap_nxt;
            sck        <= sck_nxt;
            mosi       <= mosi_nxt;
            cs         <= cs_nxt;
            tx_ready   <= ready_nxt;
            busy       <= busy_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            frame_done <= done_nxt;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum       <= csum_nxt;
            csum_sent  <= csum_sent_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        rx_sr_nxt    = rx_sr;
        bit_nxt      = bit_cnt;
        div_nxt      = div_cnt;
        byte_nxt     = byte_cnt;
        gap_nxt      = gap_cnt;
        sck_nxt      = sck;
        mosi_nxt     = mosi;
        cs_nxt       = cs;
        ready_nxt    = 1'b0;
        busy_nxt     = busy;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        done_nxt     = 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
        csum_nxt      = csum;
        csum_sent_nxt = csum_sent;
`endif
        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                cs_nxt    = 1'b1;
                if (accept) begin
                    sr_nxt    = tx_data;
                    mosi_nxt  = tx_data[7];
                    byte_nxt  = CNT_W'(1);
                    div_nxt   = '0;
                    bit_nxt   = '0;
                    cs_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    ready_nxt = 1'b0;
                    state_nxt = LOAD;
`ifdef SPI_FRAME_CHECKSUM_EN
                    csum_nxt      = tx_data;
                    csum_sent_nxt = 1'b0;
`endif
                end
            end
            LOAD: begin
                mosi_nxt = sr[7];
                if (div_cnt == DIV_LAST) begin
                    // first rising edge of the byte samples miso bit 7
                    div_nxt   = '0;
                    sck_nxt   = 1'b1;
                    rx_sr_nxt = {rx_sr[6:0], miso};
                    state_nxt = SHIFT;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_cnt != DIV_LAST) begin
                    div_nxt = div_cnt + DIV_W'(1);
                end else if (sck) begin
                    div_nxt  = '0;
                    sck_nxt  = 1'b0;
                    sr_nxt   = {sr[6:0], 1'b0};
                    mosi_nxt = sr[6];
                end else if (bit_cnt != 3'd7) begin
                    div_nxt   = '0;
                    bit_nxt   = bit_cnt + 3'd1;
                    sck_nxt   = 1'b1;
                    rx_sr_nxt = {rx_sr[6:0], miso};
                end else begin
                    // end of the low half of bit 0: the byte is complete
                    div_nxt      = '0;
                    bit_nxt      = '0;
                    rx_data_nxt  = rx_sr;
                    rx_valid_nxt = 1'b1;
                    if (byte_cnt != BYTE_LAST) begin
                        ready_nxt = 1'b1;
                        state_nxt = NEXT;
                    end
`ifdef SPI_FRAME_CHECKSUM_EN
                    else if (!csum_sent) begin
                        sr_nxt        = csum;
                        mosi_nxt      = csum[7];
                        csum_sent_nxt = 1'b1;
                        state_nxt     = LOAD;
                    end
`endif
                    else begin
                        state_nxt = HOLD;
                    end
                end
            end
            NEXT: begin
                ready_nxt = 1'b1;
                if (accept) begin
                    sr_nxt    = tx_data;
                    mosi_nxt  = tx_data[7];
                    byte_nxt  = byte_cnt + CNT_W'(1);
                    div_nxt   = '0;
                    ready_nxt = 1'b0;
                    state_nxt = LOAD;
`ifdef SPI_FRAME_CHECKSUM_EN
                    csum_nxt  = csum + tx_data;
`endif
                end
            end
            HOLD: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt   = '0;
                    gap_nxt   = '0;
                    cs_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = GAP;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: one instance at CLK_DIV=2 and one at CLK_DIV=1, FRAME_BYTES=3, CS_GAP=8.
module tb_spi_frame_master;

    localparam int FB  = 3;
    localparam int GAP = 8;
`ifdef SPI_FRAME_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mon_clr = 1'b0;
    logic       miso0;
    logic       miso1;
    logic [7:0] tx_data_w[2];
    logic       tx_valid_w[2];
    logic       tx_ready_w[2];
    logic       sck_w[2];
    logic       mosi_w[2];
    logic       cs_w[2];
    logic [7:0] rx_data_w[2];
    logic       rx_valid_w[2];
    logic       busy_w[2];
    logic       done_w[2];

    int errors = 0;
    int checks = 0;

    // Monitor state, per instance
    int         nb[2], bits[2], rises[2], edges[2], hr[2], maxhr[2];
    int         run[2], first_low[2], first_high[2], done_cnt[2], rxn[2];
    logic       prev_sck[2], prev_cs[2], seen_low[2];
    logic [7:0] cur[2];
    logic [7:0] cap[2][16];
    logic [7:0] rxq[2][16];
    logic [7:0] pat[16];
    logic [7:0] exp_b[16];
    int         exp_n;

    always #5 clk = ~clk;

    spi_frame_master #(.CLK_DIV(2), .FRAME_BYTES(FB), .CS_GAP(GAP)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]),
        .tx_ready(tx_ready_w[0]), .sck(sck_w[0]), .mosi(mosi_w[0]), .cs(cs_w[0]),
        .miso(miso0), .rx_data(rx_data_w[0]), .rx_valid(rx_valid_w[0]),
        .busy(busy_w[0]), .frame_done(done_w[0])
    );

    spi_frame_master #(.CLK_DIV(1), .FRAME_BYTES(FB), .CS_GAP(GAP)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]),
        .tx_ready(tx_ready_w[1]), .sck(sck_w[1]), .mosi(mosi_w[1]), .cs(cs_w[1]),
        .miso(miso1), .rx_data(rx_data_w[1]), .rx_valid(rx_valid_w[1]),
        .busy(busy_w[1]), .frame_done(done_w[1])
    );

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mon_clr) begin
                nb[d] <= 0; bits[d] <= 0; rises[d] <= 0; edges[d] <= 0;
                hr[d] <= 0; maxhr[d] <= 0; run[d] <= 0; first_low[d] <= -1;
                first_high[d] <= -1; seen_low[d] <= 1'b0; done_cnt[d] <= 0; rxn[d] <= 0;
                prev_sck[d] <= sck_w[d]; prev_cs[d] <= cs_w[d];
            end else begin
                prev_sck[d] <= sck_w[d];
                prev_cs[d]  <= cs_w[d];
                if (sck_w[d] != prev_sck[d]) edges[d] <= edges[d] + 1;
                if (sck_w[d] && !prev_sck[d]) begin
                    cur[d]   <= {cur[d][6:0], mosi_w[d]};
                    rises[d] <= rises[d] + 1;
                    if (bits[d] == 7) begin
                        if (nb[d] < 16) cap[d][nb[d]] <= {cur[d][6:0], mosi_w[d]};
                        nb[d]   <= nb[d] + 1;
                        bits[d] <= 0;
                    end else begin
                        bits[d] <= bits[d] + 1;
                    end
                end
                if (sck_w[d]) begin
                    hr[d] <= hr[d] + 1;
                    if (hr[d] + 1 > maxhr[d]) maxhr[d] <= hr[d] + 1;
                end else begin
                    hr[d] <= 0;
                end
                if (cs_w[d] == prev_cs[d]) begin
                    run[d] <= run[d] + 1;
                end else begin
                    run[d] <= 1;
                    if (!prev_cs[d] && first_low[d] < 0) first_low[d] <= run[d];
                    if (!prev_cs[d]) seen_low[d] <= 1'b1;
                    if (prev_cs[d] && seen_low[d] && first_high[d] < 0) first_high[d] <= run[d];
                end
                if (done_w[d]) done_cnt[d] <= done_cnt[d] + 1;
                if (rx_valid_w[d]) begin
                    if (rxn[d] < 16) rxq[d][rxn[d]] <= rx_data_w[d];
                    rxn[d] <= rxn[d] + 1;
                end
            end
        end
    end

    // Slave model for instance 0: presents pat[byte] MSB first, changing only after a rising edge
    always @(negedge clk) begin
        if (mon_clr) begin
            miso0 <= pat[0][7];
        end else if (sck_w[0] && !prev_sck[0]) begin
            if (bits[0] == 7) miso0 <= pat[(nb[0] + 1) % 16][7];
            else              miso0 <= pat[nb[0] % 16][6 - bits[0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic push(input int d, input logic [7:0] b);
        int n;
        tx_data_w[d]  = b;
        tx_valid_w[d] = 1'b1;
        n = 0;
        while (!tx_ready_w[d] && n < 3000) begin
            tick();
            n++;
        end
        check("accept_wait", 32'(n < 3000), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (busy_w[d] && n < 3000) begin
            tick();
            n++;
        end
        check("idle_wait", 32'(n < 3000), 32'd1);
        tick();
    endtask

    task automatic add_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] s;
        s = a + b + c;
        exp_b[exp_n] = a; exp_b[exp_n + 1] = b; exp_b[exp_n + 2] = c;
        exp_n += 3;
        if (CK == 1) begin
            exp_b[exp_n] = s;
            exp_n += 1;
        end
    endtask

    task automatic check_bytes(input int d);
        check("byte_count", nb[d], exp_n);
        for (int i = 0; i < exp_n; i++) check("mosi_byte", cap[d][i], exp_b[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e0;
        for (int i = 0; i < 16; i++) pat[i] = 8'h96;
        pat[0] = 8'h5A;
        pat[1] = 8'hC3;
        exp_n = 0;
        miso1 = 1'b1;
        for (int d = 0; d < 2; d++) begin
            tx_valid_w[d] = 1'b0;
            tx_data_w[d]  = 8'h00;
        end

        // Reset values
        tick(); tick();
        check("rst_sck", sck_w[0], 1'b0);
        check("rst_mosi", mosi_w[0], 1'b0);
        check("rst_cs", cs_w[0], 1'b1);
        check("rst_tx_ready", tx_ready_w[0], 1'b0);
        check("rst_rx_data", rx_data_w[0], 8'h00);
        check("rst_rx_valid", rx_valid_w[0], 1'b0);
        check("rst_busy", busy_w[0], 1'b0);
        check("rst_frame_done", done_w[0], 1'b0);
        rst = 1'b0;
        tick();
        check("idle_tx_ready", tx_ready_w[0], 1'b1);
        check("idle_cs", cs_w[0], 1'b1);

        // Two back-to-back frames with tx_valid held high; miso returns 5A then C3
        clr_mon();
        exp_n = 0;
        add_frame(8'hA5, 8'h3C, 8'hFF);
        add_frame(8'h12, 8'h34, 8'h56);
        push(0, 8'hA5); push(0, 8'h3C); push(0, 8'hFF);
        push(0, 8'h12); push(0, 8'h34); push(0, 8'h56);
        tx_valid_w[0] = 1'b0;
        wait_idle(0);
        check_bytes(0);
        check("rx_valid_count", rxn[0], exp_n);
        check("rx_byte1", rxq[0][0], 8'h5A);
        check("rx_byte2", rxq[0][1], 8'hC3);
        check("cs_low_cycles", first_low[0], 106 + 34 * CK);
        check("cs_gap_cycles", first_high[0], GAP + 1);
        check("frame_done_pulses", done_cnt[0], 2);
        check("sck_high_cycles", maxhr[0], 2);
        check("sck_rises", rises[0], 8 * exp_n);
        check("end_cs", cs_w[0], 1'b1);

        // Underflow stall after byte 1
        clr_mon();
        exp_n = 0;
        add_frame(8'h11, 8'h22, 8'h33);
        push(0, 8'h11);
        tx_valid_w[0] = 1'b0;
        n = 0;
        while (!tx_ready_w[0] && n < 500) begin
            tick();
            n++;
        end
        check("stall_ready_wait", 32'(n < 500), 32'd1);
        e0 = edges[0];
        repeat (50) tick();
        check("stall_sck_edges", edges[0], e0);
        check("stall_cs", cs_w[0], 1'b0);
        check("stall_tx_ready", tx_ready_w[0], 1'b1);
        check("stall_busy", busy_w[0], 1'b1);
        push(0, 8'h22); push(0, 8'h33);
        tx_valid_w[0] = 1'b0;
        wait_idle(0);
        check_bytes(0);
        check("stall_frame_done", done_cnt[0], 1);

        // Reset in the middle of byte 2, then a clean frame
        clr_mon();
        push(0, 8'h44); push(0, 8'h55);
        tx_valid_w[0] = 1'b0;
        n = 0;
        while (rises[0] < 12 && n < 500) begin
            tick();
            n++;
        end
        check("midframe_wait", 32'(n < 500), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_cs", cs_w[0], 1'b1);
        check("midrst_sck", sck_w[0], 1'b0);
        check("midrst_mosi", mosi_w[0], 1'b0);
        check("midrst_busy", busy_w[0], 1'b0);
        check("midrst_tx_ready", tx_ready_w[0], 1'b0);
        tick();
        rst = 1'b0;
        tick();
        clr_mon();
        exp_n = 0;
        add_frame(8'h80, 8'h90, 8'h01);
        push(0, 8'h80); push(0, 8'h90); push(0, 8'h01);
        tx_valid_w[0] = 1'b0;
        wait_idle(0);
        check_bytes(0);
        check("after_rst_cs_low", first_low[0], 106 + 34 * CK);
        check("after_rst_done", done_cnt[0], 1);

        // CLK_DIV=1 instance, two frames back-to-back
        clr_mon();
        exp_n = 0;
        add_frame(8'hC3, 8'h5A, 8'h96);
        add_frame(8'h01, 8'h02, 8'h80);
        push(1, 8'hC3); push(1, 8'h5A); push(1, 8'h96);
        push(1, 8'h01); push(1, 8'h02); push(1, 8'h80);
        tx_valid_w[1] = 1'b0;
        wait_idle(1);
        check_bytes(1);
        check("div1_cs_low", first_low[1], 54 + 17 * CK);
        check("div1_gap", first_high[1], GAP + 1);
        check("div1_sck_high", maxhr[1], 1);
        check("div1_done", done_cnt[1], 2);
        check("div1_rx_valid", rxn[1], exp_n);
        check("div1_rx_data", rx_data_w[1], 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
